// File: rtl/ms_serial_port_if.sv
// Bundle of the request/response handshake and main-store serial bus signals.
// The slave modport is the serial port block; the master modport is the CPU/store side.
interface ms_serial_port_if #(
    parameter int INSTR_BITS      = 20,
    parameter int INSTR_ADDR_BITS = 10
);
    logic                       w_REQ_VALID;
    logic                       w_REQ_READY;
    logic                       w_REQ_WRITE;
    logic [INSTR_ADDR_BITS-1:0] b_REQ_ADDR;
    logic [INSTR_BITS-1:0]      b_REQ_WDATA;
    logic                       w_RESP_VALID;
    logic [INSTR_BITS-1:0]      b_RESP_RDATA;
    logic [INSTR_ADDR_BITS-1:0] b_MS_ADDR;
    logic                       w_XTB;
    logic                       w_MS_ZERO;
    logic                       w_MS_DATA_IN;
    logic                       w_MS_DATA_OUT;
    logic                       w_BEAT0;

    modport slave (
        input  w_REQ_VALID, w_REQ_WRITE, b_REQ_ADDR, b_REQ_WDATA, w_MS_DATA_OUT,
        output w_REQ_READY, w_RESP_VALID, b_RESP_RDATA, b_MS_ADDR,
               w_XTB, w_MS_ZERO, w_MS_DATA_IN, w_BEAT0
    );

    modport master (
        output w_REQ_VALID, w_REQ_WRITE, b_REQ_ADDR, b_REQ_WDATA, w_MS_DATA_OUT,
        input  w_REQ_READY, w_RESP_VALID, b_RESP_RDATA, b_MS_ADDR,
               w_XTB, w_MS_ZERO, w_MS_DATA_IN, w_BEAT0
    );
endinterface

// File: rtl/ms_serial_port.sv
// CPU-side end of the main-store serial digit bus: turns parallel word requests into
// beat-aligned serial traffic and deserialises read digits back into a word.
module ms_serial_port #(
    parameter int INSTR_BITS      = 20,
    parameter int INSTR_ADDR_BITS = 10,
    parameter int FLYBACK_TIME    = 4,
    parameter int READ_LATENCY    = 2
) (
    input  logic             w_DPG,
    input  logic             w_RST_N,
    ms_serial_port_if.slave  bus
);
    localparam int P  = INSTR_BITS + FLYBACK_TIME;
    localparam int CW = $clog2(P);
    localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);
    localparam logic [CW-1:0] CNT_XTB  = CW'(INSTR_BITS);

    typedef enum logic [1:0] {IDLE, ALIGN, XFER, DONE} state_e;

    state_e                     state_q, state_d;
    logic [CW-1:0]              counter_q, counter_d;
    logic                       write_q, write_d;
    logic [INSTR_ADDR_BITS-1:0] addr_q, addr_d;
    logic [INSTR_BITS-1:0]      wdata_q, wdata_d;
    logic [INSTR_BITS-1:0]      shift_q, shift_d;
    logic [INSTR_BITS-1:0]      rdata_q, rdata_d;
    logic [INSTR_ADDR_BITS-1:0] msAddr_q, msAddr_d;
    logic                       ready_q, ready_d;
    logic                       respValid_q, respValid_d;
    logic                       xtb_q, xtb_d;
    logic                       zero_q, zero_d;
    logic                       dataIn_q, dataIn_d;

    // Bus outputs are registered from the next state/counter so they line up with the beat.
    always_comb begin
        state_d     = state_q;
        counter_d   = (counter_q == CNT_LAST) ? '0 : counter_q + CW'(1);
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        shift_d     = shift_q;
        rdata_d     = rdata_q;
        msAddr_d    = msAddr_q;
        ready_d     = 1'b0;
        respValid_d = 1'b0;
        xtb_d       = 1'b0;
        zero_d      = 1'b0;
        dataIn_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.w_REQ_VALID && ready_q) begin
                    write_d = bus.w_REQ_WRITE;
                    addr_d  = bus.b_REQ_ADDR;
                    wdata_d = bus.b_REQ_WDATA;
                    state_d = (counter_q == CNT_LAST) ? XFER : ALIGN;
                end
            end
            ALIGN: begin
                if (counter_q == CNT_LAST) state_d = XFER;
            end
            XFER: begin
                // Digit k arrives READ_LATENCY cycles after beat position k.
                if (!write_q) begin
                    for (int k = 0; k < INSTR_BITS; k++) begin
                        if (counter_q == CW'(k + READ_LATENCY)) shift_d[k] = bus.w_MS_DATA_OUT;
                    end
                end
                if (counter_q == CNT_LAST) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d     = (state_d == IDLE);
        respValid_d = (state_d == DONE);
        if (state_d == DONE && !write_q) rdata_d = shift_d;

        if (state_d == XFER) begin
            msAddr_d = addr_d;
            if (write_d) begin
                zero_d = 1'b1;
                xtb_d  = (counter_d == CNT_XTB);
                for (int k = 0; k < INSTR_BITS; k++) begin
                    if (counter_d == CW'(k)) dataIn_d = wdata_d[k];
                end
            end
        end
    end

    always_ff @(posedge w_DPG) begin
        if (!w_RST_N) begin
            state_q     <= IDLE;
            counter_q   <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            shift_q     <= '0;
            rdata_q     <= '0;
            msAddr_q    <= '0;
            ready_q     <= 1'b0;
            respValid_q <= 1'b0;
            xtb_q       <= 1'b0;
            zero_q      <= 1'b0;
            dataIn_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            shift_q     <= shift_d;
            rdata_q     <= rdata_d;
            msAddr_q    <= msAddr_d;
            ready_q     <= ready_d;
            respValid_q <= respValid_d;
            xtb_q       <= xtb_d;
            zero_q      <= zero_d;
            dataIn_q    <= dataIn_d;
        end
    end

    assign bus.w_REQ_READY  = ready_q;
    assign bus.w_RESP_VALID = respValid_q;
    assign bus.b_RESP_RDATA = rdata_q;
    assign bus.b_MS_ADDR    = msAddr_q;
    assign bus.w_XTB        = xtb_q;
    assign bus.w_MS_ZERO    = zero_q;
    assign bus.w_MS_DATA_IN = dataIn_q;
    assign bus.w_BEAT0      = (counter_q == '0);
endmodule

// File: tb/tb_ms_serial_port.sv
// Bench for ms_serial_port with a lockstep serial main-store model and a response
// scoreboard checked against a reference memory.
module tb_ms_serial_port;
    localparam int IB = 20;
    localparam int AB = 10;
    localparam int FB = 4;
    localparam int RL = 2;
    localparam int P  = IB + FB;

    typedef struct {
        bit            isRead;
        logic [AB-1:0] addr;
        logic [IB-1:0] wdata;
        int            respCyc;
    } exp_t;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    ms_serial_port_if #(.INSTR_BITS(IB), .INSTR_ADDR_BITS(AB)) bus ();

    ms_serial_port #(
        .INSTR_BITS(IB), .INSTR_ADDR_BITS(AB), .FLYBACK_TIME(FB), .READ_LATENCY(RL)
    ) dut (
        .w_DPG  (clk),
        .w_RST_N(rstN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    logic [4:0]    tbCnt = '0;
    exp_t          sb[$];
    logic [IB-1:0] storeMem [0:(1<<AB)-1] = '{default: '0};
    logic [IB-1:0] refMem   [0:(1<<AB)-1] = '{default: '0};
    logic [IB-1:0] wShift   = '0;
    logic [IB-1:0] lastRead = '0;
    logic [IB-1:0] storeWord;
    logic          msOut;

    function automatic void checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endfunction

    // Independent beat counter: the store's read/write units count from reset release.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rstN) tbCnt <= '0;
        else       tbCnt <= (tbCnt == 5'(P - 1)) ? 5'd0 : tbCnt + 5'd1;
    end

    // Store write unit: collects serial digits, commits on XTB, ORs unless zeroed.
    always @(posedge clk) begin
        if (tbCnt < 5'(IB)) wShift[tbCnt] <= bus.w_MS_DATA_IN;
        if (bus.w_XTB === 1'b1)
            storeMem[bus.b_MS_ADDR] <= (bus.w_MS_ZERO === 1'b1) ? wShift
                                                                 : (storeMem[bus.b_MS_ADDR] | wShift);
    end

    always_comb begin
        msOut     = 1'b0;
        storeWord = '0;
        if (bus.w_MS_ZERO !== 1'b1 && tbCnt >= 5'(RL) && tbCnt < 5'(IB + RL)) begin
            storeWord = storeMem[bus.b_MS_ADDR];
            msOut     = storeWord[tbCnt - 5'(RL)];
        end
    end
    assign bus.w_MS_DATA_OUT = msOut;

    // Response monitor: pops the scoreboard and checks timing and data.
    always @(negedge clk) begin
        exp_t e;
        if (rstN && bus.w_RESP_VALID === 1'b1) begin
            checkOutput("resp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("resp_cycle", 32'(cyc), 32'(e.respCyc));
                if (e.isRead) begin
                    checkOutput("rdata", 32'(bus.b_RESP_RDATA), 32'(refMem[e.addr]));
                    lastRead = refMem[e.addr];
                end else begin
                    checkOutput("rdata_hold", 32'(bus.b_RESP_RDATA), 32'(lastRead));
                    refMem[e.addr] = e.wdata;
                end
            end
        end
    end

    task automatic applyStimulus(input bit wr, input logic [AB-1:0] a, input logic [IB-1:0] d,
                                 output int accCyc, output int respCyc);
        exp_t e;
        bit   accepted = 1'b0;
        int   lat;
        bus.w_REQ_WRITE = wr;
        bus.b_REQ_ADDR  = a;
        bus.b_REQ_WDATA = d;
        bus.w_REQ_VALID = 1'b1;
        accCyc  = 0;
        respCyc = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.w_REQ_READY === 1'b1) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("accept", 32'(accepted), 32'd1);
        if (accepted) begin
            lat       = (P - 1 - int'(tbCnt)) + P + 1;
            accCyc    = cyc;
            respCyc   = cyc + lat;
            e.isRead  = !wr;
            e.addr    = a;
            e.wdata   = d;
            e.respCyc = respCyc;
            sb.push_back(e);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic waitCount(input logic [4:0] c);
        bit hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (tbCnt == c) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("wait_count", 32'(hit), 32'd1);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 120 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic checkWriteBeat(input logic [AB-1:0] a, input logic [IB-1:0] d);
        waitCount(5'd0);
        for (int t = 0; t < P; t++) begin
            checkOutput("wr_zero", 32'(bus.w_MS_ZERO), 32'd1);
            checkOutput("wr_xtb", 32'(bus.w_XTB), 32'(t == IB));
            checkOutput("wr_din", 32'(bus.w_MS_DATA_IN), (t < IB) ? 32'(d[5'(t)]) : 32'd0);
            checkOutput("wr_addr", 32'(bus.b_MS_ADDR), 32'(a));
            checkOutput("wr_ready", 32'(bus.w_REQ_READY), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_ready", 32'(bus.w_REQ_READY), 32'd0);
        checkOutput("rst_resp", 32'(bus.w_RESP_VALID), 32'd0);
        checkOutput("rst_rdata", 32'(bus.b_RESP_RDATA), 32'd0);
        checkOutput("rst_msaddr", 32'(bus.b_MS_ADDR), 32'd0);
        checkOutput("rst_xtb", 32'(bus.w_XTB), 32'd0);
        checkOutput("rst_zero", 32'(bus.w_MS_ZERO), 32'd0);
        checkOutput("rst_din", 32'(bus.w_MS_DATA_IN), 32'd0);
        checkOutput("rst_beat0", 32'(bus.w_BEAT0), 32'd1);
    endtask

    initial begin
        int acc1, rsp1, acc2, rsp2, n;
        bus.w_REQ_VALID = 1'b0;
        bus.w_REQ_WRITE = 1'b0;
        bus.b_REQ_ADDR  = '0;
        bus.b_REQ_WDATA = '0;

        repeat (3) @(negedge clk);
        checkResetOutputs();
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(bus.w_REQ_READY), 32'd1);

        applyStimulus(1'b1, 10'd3, 20'hA5A5A, acc1, rsp1);
        bus.w_REQ_VALID = 1'b0;
        checkWriteBeat(10'd3, 20'hA5A5A);
        waitDrain();

        applyStimulus(1'b0, 10'd3, 20'h0, acc1, rsp1);
        bus.w_REQ_VALID = 1'b0;
        waitDrain();
        applyStimulus(1'b1, 10'd3, 20'h00001, acc1, rsp1);
        bus.w_REQ_VALID = 1'b0;
        waitDrain();
        applyStimulus(1'b0, 10'd3, 20'h0, acc1, rsp1);
        bus.w_REQ_VALID = 1'b0;
        waitDrain();

        // Acceptance latency measured directly from the accepting edge
        waitCount(5'd23);
        applyStimulus(1'b0, 10'd3, 20'h0, acc1, rsp1);
        bus.w_REQ_VALID = 1'b0;
        n = 1;
        while (bus.w_RESP_VALID !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("lat_c23", 32'(n), 32'd25);
        waitDrain();

        waitCount(5'd5);
        applyStimulus(1'b1, 10'd9, 20'h0, acc1, rsp1);
        bus.w_REQ_VALID = 1'b0;
        n = 1;
        while (bus.w_RESP_VALID !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("lat_c5", 32'(n), 32'd43);
        waitDrain();

        // Back-to-back with VALID held high throughout
        applyStimulus(1'b1, 10'd7, 20'hFFFFF, acc1, rsp1);
        applyStimulus(1'b0, 10'd7, 20'h0, acc2, rsp2);
        bus.w_REQ_VALID = 1'b0;
        checkOutput("b2b_accept", 32'(acc2), 32'(rsp1 + 1));
        waitDrain();

        // Reset in the middle of a write beat aborts it
        applyStimulus(1'b1, 10'd3, 20'h12345, acc1, rsp1);
        bus.w_REQ_VALID = 1'b0;
        waitCount(5'd0);
        waitCount(5'd10);
        checkOutput("abort_xtb_pre", 32'(bus.w_XTB), 32'd0);
        rstN = 1'b0;
        sb.delete();
        @(negedge clk);
        checkResetOutputs();
        lastRead = '0;
        rstN = 1'b1;
        repeat (30) @(negedge clk);
        applyStimulus(1'b0, 10'd3, 20'h0, acc1, rsp1);
        bus.w_REQ_VALID = 1'b0;
        waitDrain();

        // Requests while busy are ignored and do not disturb the in-flight address
        waitCount(5'd23);
        applyStimulus(1'b0, 10'd3, 20'h0, acc1, rsp1);
        bus.w_REQ_VALID = 1'b0;
        waitCount(5'd5);
        for (int i = 0; i < 10; i++) begin
            bus.w_REQ_VALID = 1'b1;
            bus.w_REQ_WRITE = 1'b1;
            bus.b_REQ_ADDR  = 10'(9 + i);
            bus.b_REQ_WDATA = 20'h55555;
            checkOutput("busy_msaddr", 32'(bus.b_MS_ADDR), 32'd3);
            checkOutput("busy_ready", 32'(bus.w_REQ_READY), 32'd0);
            @(negedge clk);
        end
        bus.w_REQ_VALID = 1'b0;
        waitDrain();
        repeat (60) @(negedge clk);
        applyStimulus(1'b0, 10'd9, 20'h0, acc1, rsp1);
        bus.w_REQ_VALID = 1'b0;
        waitDrain();
        applyStimulus(1'b0, 10'd7, 20'h0, acc1, rsp1);
        bus.w_REQ_VALID = 1'b0;
        waitDrain();

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
